// File: rtl/memory_request_arbiter_pkg.sv
// Shared types for the single-port memory arbiter: bus words, RAM handshake states
// and the arbiter FSM encoding.
package memory_request_arbiter_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        GNT_D  = 3'd1,
        GNT_I  = 3'd2,
        RESP_D = 3'd3,
        RESP_I = 3'd4
    } arb_state_t;

    localparam int CNT_W = 16;

    // Stall counter stops at all-ones instead of wrapping back below the timeout.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/memory_request_arbiter.sv
// Serialises instruction-fetch and data requests onto one RAM port and returns
// ihit/dhit pulses with the loaded word; flags timeouts and RAM errors in mem_err.
module memory_request_arbiter
    import memory_request_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter bit D_PRIORITY     = 1'b1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_halt,
    input  logic        i_iren,
    input  logic [31:0] i_iaddr,
    input  logic        i_dren,
    input  logic        i_dwen,
    input  logic [31:0] i_daddr,
    input  logic [31:0] i_dstore,
    output logic        o_ihit,
    output logic        o_dhit,
    output logic [31:0] o_iload,
    output logic [31:0] o_dload,
    output logic        o_ramren,
    output logic        o_ramwen,
    output logic [31:0] o_ramaddr,
    output logic [31:0] o_ramstore,
    input  logic [31:0] i_ramload,
    input  logic [1:0]  i_ramstate,
    output logic        o_mem_err
);

    localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(TIMEOUT_CYCLES);

    arb_state_t       r_state;
    logic             r_write;
    word_t            r_addr;
    word_t            r_store;
    logic [CNT_W-1:0] r_cnt;
    word_t            r_iload;
    word_t            r_dload;
    logic             r_ihit;
    logic             r_dhit;
    logic             r_ramren;
    logic             r_ramwen;
    logic             r_mem_err;

    arb_state_t       w_state_next;
    logic             w_write_next;
    word_t            w_addr_next;
    word_t            w_store_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic [CNT_W-1:0] w_cnt_inc;
    word_t            w_iload_next;
    word_t            w_dload_next;
    logic             w_mem_err_next;
    logic             w_dreq;
    logic             w_ireq;
    logic             w_gnt_next;
    logic             w_ramren_next;
    logic             w_ramwen_next;
    ramstate_t        w_ramstate;

    assign w_ramstate = ramstate_t'(i_ramstate);
    assign w_dreq     = i_dren | i_dwen;
    assign w_ireq     = i_iren & ~i_halt;
    assign w_cnt_inc  = sat_inc(r_cnt);

    always_comb begin
        w_state_next   = r_state;
        w_write_next   = r_write;
        w_addr_next    = r_addr;
        w_store_next   = r_store;
        w_cnt_next     = r_cnt;
        w_iload_next   = r_iload;
        w_dload_next   = r_dload;
        // A simultaneous read and write is served as a write but flagged.
        w_mem_err_next = r_mem_err | (i_dren & i_dwen);
        case (r_state)
            IDLE: begin
                if (w_dreq && (D_PRIORITY || !w_ireq)) begin
                    w_state_next = GNT_D;
                    w_write_next = i_dwen;
                    w_addr_next  = i_daddr;
                    w_store_next = i_dstore;
                    w_cnt_next   = '0;
                end else if (w_ireq) begin
                    w_state_next = GNT_I;
                    w_write_next = 1'b0;
                    w_addr_next  = i_iaddr;
                    w_cnt_next   = '0;
                end
            end
            GNT_D, GNT_I: begin
                case (w_ramstate)
                    ACCESS: begin
                        if (r_state == GNT_I) begin
                            w_iload_next = i_ramload;
                            w_state_next = RESP_I;
                        end else begin
                            if (!r_write) begin
                                w_dload_next = i_ramload;
                            end
                            w_state_next = RESP_D;
                        end
                    end
                    ERROR: w_mem_err_next = 1'b1;
                    default: begin
                        // Timeout only raises the flag; the access keeps waiting.
                        w_cnt_next = w_cnt_inc;
                        if (w_cnt_inc == TIMEOUT_VAL) begin
                            w_mem_err_next = 1'b1;
                        end
                    end
                endcase
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign w_gnt_next    = (w_state_next == GNT_D) || (w_state_next == GNT_I);
    assign w_ramren_next = w_gnt_next && !w_write_next;
    assign w_ramwen_next = (w_state_next == GNT_D) && w_write_next;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= IDLE;
            r_write   <= 1'b0;
            r_addr    <= '0;
            r_store   <= '0;
            r_cnt     <= '0;
            r_iload   <= '0;
            r_dload   <= '0;
            r_ihit    <= 1'b0;
            r_dhit    <= 1'b0;
            r_ramren  <= 1'b0;
            r_ramwen  <= 1'b0;
            r_mem_err <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_write   <= w_write_next;
            r_addr    <= w_addr_next;
            r_store   <= w_store_next;
            r_cnt     <= w_cnt_next;
            r_iload   <= w_iload_next;
            r_dload   <= w_dload_next;
            r_ihit    <= (w_state_next == RESP_I);
            r_dhit    <= (w_state_next == RESP_D);
            r_ramren  <= w_ramren_next;
            r_ramwen  <= w_ramwen_next;
            r_mem_err <= w_mem_err_next;
        end
    end

    assign o_ihit     = r_ihit;
    assign o_dhit     = r_dhit;
    assign o_iload    = r_iload;
    assign o_dload    = r_dload;
    assign o_ramren   = r_ramren;
    assign o_ramwen   = r_ramwen;
    assign o_ramaddr  = r_addr;
    assign o_ramstore = r_store;
    assign o_mem_err  = r_mem_err;

endmodule
